// File: rtl/mix_engine_pkg.sv
// mix_engine_pkg: state encoding, width defaults and index-width helper for the mix engine
package mix_engine_pkg;
    localparam int DEF_VOICES   = 3;
    localparam int DEF_SAMPLE_W = 14;
    localparam int DEF_VOL_W    = 8;
    localparam int DEF_MULT_A_W = 24;
    localparam int DEF_MULT_B_W = 16;
    localparam int DEF_PROD_W   = 40;
    localparam int DEF_FRAC     = 8;

    typedef enum logic [2:0] {
        IDLE, COLLECT, FILT_REQ, FILT_WAIT, VOL_REQ, VOL_WAIT, OUT
    } mix_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mix_sat.sv
// mix_sat: signed saturator narrowing IN_W bits to OUT_W bits
module mix_sat #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 14
) (
    input  logic signed [IN_W-1:0]  i_d,
    output logic signed [OUT_W-1:0] o_q
);
    localparam logic signed [OUT_W-1:0] MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN = {1'b1, {(OUT_W-1){1'b0}}};

    assign o_q = (i_d > IN_W'(MAX)) ? MAX : (i_d < IN_W'(MIN)) ? MIN : i_d[OUT_W-1:0];
endmodule

// File: rtl/mix_engine.sv
// mix_engine: per-frame voice accumulator feeding the SVF, bypass mix and master volume
// through the shared multiplier, emitting one saturated audio sample per frame.
module mix_engine
    import mix_engine_pkg::*;
#(
    parameter int NUM_VOICES = DEF_VOICES,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int VOL_W      = DEF_VOL_W,
    parameter int MULT_A_W   = DEF_MULT_A_W,
    parameter int MULT_B_W   = DEF_MULT_B_W,
    parameter int PROD_W     = DEF_PROD_W,
    parameter int FRAC_SHIFT = DEF_FRAC,
    localparam int IDX_W     = idx_w(NUM_VOICES)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       frame_start_i,
    input  logic                       voice_valid_i,
    input  logic [IDX_W-1:0]           voice_idx_i,
    input  logic signed [SAMPLE_W-1:0] voice_sample_i,
    input  logic [NUM_VOICES-1:0]      route_mask_i,
    output logic                       filt_start_o,
    output logic signed [SAMPLE_W-1:0] filt_in_o,
    input  logic                       filt_ready_i,
    input  logic signed [SAMPLE_W-1:0] filt_out_i,
    input  logic [VOL_W-1:0]           volume_i,
    output logic                       mult_start_o,
    output logic signed [MULT_A_W-1:0] mult_a_o,
    output logic [MULT_B_W-1:0]        mult_b_o,
    input  logic                       mult_ready_i,
    input  logic signed [PROD_W-1:0]   mult_prod_i,
    output logic signed [SAMPLE_W-1:0] audio_o,
    output logic                       audio_valid_o,
    output logic                       busy_o,
    output logic                       overrun_o
);
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam logic [IDX_W:0] NV = (IDX_W+1)'(NUM_VOICES);

    mix_state_e                r_state;
    logic signed [ACC_W-1:0]   r_filt_acc, r_byp_acc;
    logic signed [SAMPLE_W-1:0] r_filt_cap, r_audio;
    logic [NUM_VOICES-1:0]     r_rcvd, r_mask;
    logic [VOL_W-1:0]          r_vol;
    logic                      r_filt_vld, r_filt_start, r_mult_start, r_audio_valid, r_overrun;

    logic                      w_hit, w_to_filt, w_mult_on;
    logic [NUM_VOICES-1:0]     w_one, w_rcvd;
    logic signed [ACC_W-1:0]   w_samp;
    logic signed [ACC_W:0]     w_sum;
    logic signed [PROD_W-1:0]  w_shift;
    logic signed [SAMPLE_W-1:0] w_filt_sat, w_mix, w_audio;

    assign w_hit     = voice_valid_i && ({1'b0, voice_idx_i} < NV) && !r_rcvd[voice_idx_i];
    assign w_to_filt = r_mask[voice_idx_i];
    assign w_one     = w_hit ? NUM_VOICES'(1) << voice_idx_i : '0;
    assign w_rcvd    = r_rcvd | w_one;
    assign w_samp    = ACC_W'(voice_sample_i);
    assign w_sum     = (ACC_W+1)'(r_filt_cap) + (ACC_W+1)'(r_byp_acc);
    assign w_shift   = mult_prod_i >>> FRAC_SHIFT;
    assign w_mult_on = (r_state == VOL_REQ) || (r_state == VOL_WAIT);

    mix_sat #(.IN_W(ACC_W),   .OUT_W(SAMPLE_W)) u_filt_sat (.i_d(r_filt_acc), .o_q(w_filt_sat));
    mix_sat #(.IN_W(ACC_W+1), .OUT_W(SAMPLE_W)) u_mix_sat  (.i_d(w_sum),      .o_q(w_mix));
    mix_sat #(.IN_W(PROD_W),  .OUT_W(SAMPLE_W)) u_out_sat  (.i_d(w_shift),    .o_q(w_audio));

    // operands idle at zero so several clients can OR onto the shared multiplier bus
    assign mult_a_o      = w_mult_on ? MULT_A_W'(w_mix) : '0;
    assign mult_b_o      = w_mult_on ? MULT_B_W'(r_vol) : '0;
    assign filt_in_o     = r_filt_vld ? w_filt_sat : '0;
    assign filt_start_o  = r_filt_start;
    assign mult_start_o  = r_mult_start;
    assign audio_o       = r_audio;
    assign audio_valid_o = r_audio_valid;
    assign overrun_o     = r_overrun;
    assign busy_o        = r_state != IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_filt_acc    <= '0;
            r_byp_acc     <= '0;
            r_filt_cap    <= '0;
            r_audio       <= '0;
            r_rcvd        <= '0;
            r_mask        <= '0;
            r_vol         <= '0;
            r_filt_vld    <= 1'b0;
            r_filt_start  <= 1'b0;
            r_mult_start  <= 1'b0;
            r_audio_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_filt_start  <= 1'b0;
            r_mult_start  <= 1'b0;
            r_audio_valid <= 1'b0;
            r_overrun     <= frame_start_i && (r_state != IDLE);
            case (r_state)
                IDLE: if (frame_start_i) begin
                    r_state    <= COLLECT;
                    r_filt_acc <= '0;
                    r_byp_acc  <= '0;
                    r_filt_cap <= '0;
                    r_rcvd     <= '0;
                    r_filt_vld <= 1'b0;
                    r_mask     <= route_mask_i;
                    r_vol      <= volume_i;
                end
                COLLECT: begin
                    if (w_hit && w_to_filt) r_filt_acc <= r_filt_acc + w_samp;
                    if (w_hit && !w_to_filt) r_byp_acc <= r_byp_acc + w_samp;
                    r_rcvd <= w_rcvd;
                    if (&w_rcvd) begin
                        r_state      <= (|r_mask) ? FILT_REQ : VOL_REQ;
                        r_filt_start <= |r_mask;
                        r_filt_vld   <= |r_mask;
                        r_mult_start <= ~|r_mask;
                    end
                end
                FILT_REQ: r_state <= FILT_WAIT;
                FILT_WAIT: if (filt_ready_i) begin
                    r_filt_cap   <= filt_out_i;
                    r_state      <= VOL_REQ;
                    r_mult_start <= 1'b1;
                end
                VOL_REQ: r_state <= VOL_WAIT;
                VOL_WAIT: if (mult_ready_i) begin
                    r_audio       <= w_audio;
                    r_audio_valid <= 1'b1;
                    r_state       <= OUT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_engine.sv
// tb_mix_engine: table-driven frames with an audio scoreboard, plus duplicate, overrun,
// reset and 8-voice sequences.
module tb_mix_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic fs, vv, frdy, mrdy, fstart, mstart, avld, busy, ovr;
    logic [1:0] vidx;
    logic [2:0] route;
    logic [7:0] vol, cur_vol;
    logic signed [13:0] vs, fin, fout, aud;
    logic signed [23:0] ma;
    logic [15:0] mb;
    logic signed [39:0] mprod;

    logic fs8, vv8, mrdy8, fstart8, mstart8, avld8, busy8, ovr8;
    logic [2:0] vidx8;
    logic [7:0] route8, vol8;
    logic signed [13:0] vs8, fin8, aud8;
    logic signed [23:0] ma8;
    logic [15:0] mb8;
    logic signed [39:0] mprod8;

    int n_chk = 0, n_fail = 0, n_vld = 0, n_fs = 0, fs_base = 0, vld_base = 0;
    logic signed [13:0] q[$];

    typedef struct {
        logic [2:0] mask;
        logic [7:0] vol;
        logic signed [13:0] s0, s1, s2, svf, fin, mix;
        logic signed [39:0] prod;
        logic signed [13:0] aud;
        int dly;
    } vec_t;
    vec_t tv[7];

    mix_engine #(.NUM_VOICES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs), .voice_valid_i(vv),
        .voice_idx_i(vidx), .voice_sample_i(vs), .route_mask_i(route),
        .filt_start_o(fstart), .filt_in_o(fin), .filt_ready_i(frdy), .filt_out_i(fout),
        .volume_i(vol), .mult_start_o(mstart), .mult_a_o(ma), .mult_b_o(mb),
        .mult_ready_i(mrdy), .mult_prod_i(mprod), .audio_o(aud), .audio_valid_o(avld),
        .busy_o(busy), .overrun_o(ovr)
    );

    mix_engine #(.NUM_VOICES(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs8), .voice_valid_i(vv8),
        .voice_idx_i(vidx8), .voice_sample_i(vs8), .route_mask_i(route8),
        .filt_start_o(fstart8), .filt_in_o(fin8), .filt_ready_i(1'b0), .filt_out_i(14'sd0),
        .volume_i(vol8), .mult_start_o(mstart8), .mult_a_o(ma8), .mult_b_o(mb8),
        .mult_ready_i(mrdy8), .mult_prod_i(mprod8), .audio_o(aud8), .audio_valid_o(avld8),
        .busy_o(busy8), .overrun_o(ovr8)
    );

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fstart) n_fs++;
        if (avld) begin
            n_vld++;
            if (q.size() == 0) check("spurious_audio_valid", avld, 0);
            else check("audio", aud, q.pop_front());
        end
    end

    task automatic start_frame(input logic [2:0] m, input logic [7:0] v, input logic signed [13:0] ea);
        fs = 1'b1; route = m; vol = v; cur_vol = v;
        q.push_back(ea);
        fs_base = n_fs; vld_base = n_vld;
        @(negedge clk);
        fs = 1'b0; route = 3'($urandom); vol = 8'($urandom);
        check("busy_start", busy, 1);
    endtask

    task automatic strobe(input logic [1:0] i, input logic signed [13:0] s);
        vv = 1'b1; vidx = i; vs = s;
        @(negedge clk);
        vv = 1'b0;
    endtask

    task automatic finish(input logic signed [13:0] svf, efin, emix, input logic signed [39:0] prod,
                          input bit uf, input int dly, input bit ov, input bit ov_out);
        int t;
        longint t0;
        t0 = longint'($time);
        if (uf) begin
            t = 0;
            while (!fstart && t < 20) begin @(negedge clk); t++; end
            check("filt_start", fstart, 1);
            check("filt_in", fin, efin);
            @(negedge clk);
            check("filt_start_len", fstart, 0);
            check("mult_a_idle", ma, 0);
            if (ov) begin
                fs = 1'b1; @(negedge clk); fs = 1'b0;
                check("overrun", ovr, 1);
                @(negedge clk);
                check("overrun_len", ovr, 0);
                check("busy_ovr", busy, 1);
            end
            repeat (dly) @(negedge clk);
            frdy = 1'b1; fout = svf;
            @(negedge clk);
            frdy = 1'b0; fout = '0;
            check("filt_in_hold", fin, efin);
        end
        t = 0;
        while (!mstart && t < 20) begin @(negedge clk); t++; end
        check("mult_start", mstart, 1);
        check("mult_a", ma, emix);
        check("mult_b", mb, cur_vol);
        check("filt_start_count", n_fs - fs_base, uf);
        @(negedge clk);
        check("mult_start_len", mstart, 0);
        check("mult_a_hold", ma, emix);
        repeat (dly) @(negedge clk);
        mrdy = 1'b1; mprod = prod;
        @(negedge clk);
        mrdy = 1'b0; mprod = '0;
        check("audio_valid", avld, 1);
        if (uf && dly == 0 && !ov) check("latency", longint'($time) - t0, 40);
        if (ov_out) fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        check("audio_valid_len", avld, 0);
        check("busy_end", busy, 0);
        if (ov_out) check("overrun_out", ovr, 1);
        check("valid_count", n_vld - vld_base, 1);
    endtask

    task automatic run_vec(input int k, input bit ov, input bit ov_out);
        start_frame(tv[k].mask, tv[k].vol, tv[k].aud);
        strobe(2'd0, tv[k].s0);
        strobe(2'd1, tv[k].s1);
        strobe(2'd2, tv[k].s2);
        finish(tv[k].svf, tv[k].fin, tv[k].mix, tv[k].prod, |tv[k].mask, tv[k].dly, ov, ov_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        tv[0] = '{3'b000, 8'd255, 14'sd1000, 14'sd2000, -14'sd500, 14'sd0, 14'sd0, 14'sd2500, 40'sd637500, 14'sd2490, 0};
        tv[1] = '{3'b011, 8'd128, 14'sd8191, 14'sd8191, 14'sd100, 14'sd4000, 14'sd8191, 14'sd4100, 40'sd524800, 14'sd2050, 0};
        tv[2] = '{3'b111, 8'd200, -14'sd8192, -14'sd8192, -14'sd8192, -14'sd3000, -14'sd8192, -14'sd3000, -40'sd600000, -14'sd2344, 1};
        tv[3] = '{3'b100, 8'd255, 14'sd5000, 14'sd5000, -14'sd7000, 14'sd8191, -14'sd7000, 14'sd8191, 40'sd2088705, 14'sd8159, 2};
        tv[4] = '{3'b001, 8'd0, 14'sd100, 14'sd200, 14'sd300, 14'sd50, 14'sd100, 14'sd550, 40'sd0, 14'sd0, 0};
        tv[5] = '{3'b000, 8'd255, 14'sd1, 14'sd2, 14'sd3, 14'sd0, 14'sd0, 14'sd6, 40'sd5000000, 14'sd8191, 1};
        tv[6] = '{3'b010, 8'd255, 14'sd10, -14'sd20, 14'sd30, -14'sd5, -14'sd20, 14'sd35, -40'sd5000000, -14'sd8192, 0};

        rst_n = 1'b0; fs = 0; vv = 0; vidx = 0; vs = 0; route = 0; vol = 0; cur_vol = 0;
        frdy = 0; fout = 0; mrdy = 0; mprod = 0;
        fs8 = 0; vv8 = 0; vidx8 = 0; vs8 = 0; route8 = 0; vol8 = 0; mrdy8 = 0; mprod8 = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_audio", aud, 0);
        check("rst_valid", avld, 0);
        check("rst_starts", {fstart, mstart, ovr}, 0);
        check("rst_mult_a", ma, 0);
        check("rst_mult_b", mb, 0);
        check("rst_filt_in", fin, 0);
        check("rst_busy8", busy8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(k, 1'b0, 1'b0);

        // duplicate and out-of-range strobes are dropped; frame keeps waiting
        start_frame(3'b000, 8'd255, 14'sd498);
        strobe(2'd0, 14'sd500);
        strobe(2'd0, 14'sd700);
        strobe(2'd3, 14'sd999);
        repeat (3) @(negedge clk);
        check("dup_busy", busy, 1);
        check("dup_no_progress", mstart, 0);
        strobe(2'd1, 14'sd0);
        strobe(2'd2, 14'sd0);
        finish(14'sd0, 14'sd0, 14'sd500, 40'sd127500, 1'b0, 0, 1'b0, 1'b0);

        run_vec(1, 1'b1, 1'b1);
        run_vec(0, 1'b0, 1'b0);
        run_vec(1, 1'b0, 1'b0);

        // reset while waiting on the multiplier
        start_frame(3'b000, 8'd255, 14'sd0);
        strobe(2'd0, 14'sd100);
        strobe(2'd1, 14'sd100);
        strobe(2'd2, 14'sd100);
        t = 0;
        while (!mstart && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        check("pre_rst_mult_a", ma, 300);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_audio", aud, 0);
        check("mid_rst_mult", {ma, mb}, 0);
        check("mid_rst_flags", {avld, fstart, mstart, ovr}, 0);
        q.delete();
        @(negedge clk);
        mrdy = 1'b1; mprod = 40'sd76500;
        @(negedge clk);
        mrdy = 1'b0; mprod = '0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_valid_after_rst", n_vld - vld_base, 0);
        run_vec(1, 1'b0, 1'b0);

        // eight-voice instance, full negative bypass saturates the mix
        fs8 = 1'b1; route8 = 8'h00; vol8 = 8'd255;
        @(negedge clk);
        fs8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vv8 = 1'b1; vidx8 = 3'(i); vs8 = -14'sd8192;
            @(negedge clk);
        end
        vv8 = 1'b0;
        t = 0;
        while (!mstart8 && t < 20) begin @(negedge clk); t++; end
        check("v8_mult_start", mstart8, 1);
        check("v8_mult_a", ma8, -8192);
        check("v8_mult_b", mb8, 255);
        check("v8_no_filt", fstart8, 0);
        @(negedge clk);
        mrdy8 = 1'b1; mprod8 = -40'sd2088960;
        @(negedge clk);
        mrdy8 = 1'b0; mprod8 = '0;
        check("v8_valid", avld8, 1);
        check("v8_audio", aud8, -8160);
        @(negedge clk);
        check("v8_idle", busy8, 0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
